// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus: word request held until ack, read data valid with ack.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch.sv
// IF stage of the 5-stage MIPS core: sequential word fetch over a req/ack bus,
// a one-entry buffer for data returned while decode stalls, and redirect
// handling that always delivers the branch-delay slot before the target.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0040_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   instr_fetch_if.master imem,
   input  logic          stall,
   input  logic          jump_branch,
   input  logic          jump_target,
   input  logic          jump_reg,
   input  logic [31:0]   jr_pc,
   output logic [31:0]   pc_id,
   output logic [31:0]   instr_id
);

   typedef enum logic [1:0] {IDLE, REQ, BUF} state_t;

   state_t      state_q,     state_d;
   logic [31:0] fetch_pc_q,  fetch_pc_d;
   logic [31:0] addr_q,      addr_d;
   logic [31:0] pc_id_q,     pc_id_d;
   logic [31:0] instr_id_q,  instr_id_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc_q,    buf_pc_d;

   logic [31:0] pc_id_plus4;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] redir_target;
   logic [31:0] next_addr;
   logic        redirect;
   logic        issue;

   // Redirect target from the instruction held in ID; register > jump > branch.
   always_comb begin
      pc_id_plus4  = pc_id_q + 32'd4;
      br_target    = pc_id_plus4 + {{14{instr_id_q[15]}}, instr_id_q[15:0], 2'b00};
      j_target     = (pc_id_plus4 & 32'hF000_0000) | {4'b0000, instr_id_q[25:0], 2'b00};
      redirect     = !stall && (jump_branch || jump_target || jump_reg);
      if (jump_reg) begin
         redir_target = jr_pc & 32'hFFFF_FFFC;
      end else if (jump_target) begin
         redir_target = j_target;
      end else begin
         redir_target = br_target;
      end
      next_addr = redirect ? redir_target : fetch_pc_q;
   end

   // Fetch FSM: issue control, ID register update and delay-slot-aware fetch_pc.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      addr_d      = addr_q;
      pc_id_d     = pc_id_q;
      instr_id_d  = instr_id_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      issue       = 1'b0;

      case (state_q)
         IDLE: begin
            issue   = 1'b1;
            state_d = REQ;
         end
         REQ: begin
            if (imem.imem_ack) begin
               if (stall) begin
                  buf_instr_d = imem.imem_rdata;
                  buf_pc_d    = addr_q;
                  state_d     = BUF;
               end else begin
                  instr_id_d = imem.imem_rdata;
                  pc_id_d    = addr_q;
                  issue      = 1'b1;
               end
            end else if (!stall) begin
               instr_id_d = NOP_INSTR;
            end
         end
         BUF: begin
            if (!stall) begin
               instr_id_d = buf_instr_q;
               pc_id_d    = buf_pc_q;
               issue      = 1'b1;
               state_d    = REQ;
            end
         end
         default: state_d = IDLE;
      endcase

      // The delay slot is already in flight when a redirect is accepted, so
      // the target either goes out now (bypass) or waits in fetch_pc.
      if (issue) begin
         addr_d     = next_addr;
         fetch_pc_d = next_addr + 32'd4;
      end else if (redirect) begin
         fetch_pc_d = redir_target;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         addr_q      <= RESET_PC;
         pc_id_q     <= '0;
         instr_id_q  <= NOP_INSTR;
         buf_instr_q <= NOP_INSTR;
         buf_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         addr_q      <= addr_d;
         pc_id_q     <= pc_id_d;
         instr_id_q  <= instr_id_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

   assign imem.imem_req  = (state_q == REQ);
   assign imem.imem_addr = addr_q;
   assign pc_id          = pc_id_q;
   assign instr_id       = instr_id_q;

endmodule
